// File: rtl/reel_stop_ctrl_pkg.sv
// ============================================================================
// Module      : reel_stop_ctrl_pkg
// Description : Shared state encodings, payout multipliers and credit helpers
//               for the reel stop controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reel_stop_ctrl_pkg;

  // Controller states, encoded explicitly in three bits
  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_SPIN  = 3'd1;
  localparam state_t S_STOP1 = 3'd2;
  localparam state_t S_STOP2 = 3'd3;
  localparam state_t S_EVAL  = 3'd4;
  localparam state_t S_DONE  = 3'd5;

  // Payout multipliers applied to the wager
  localparam logic [7:0] MULT_JACKPOT = 8'd50;
  localparam logic [7:0] MULT_TRIPLE  = 8'd10;
  localparam logic [7:0] MULT_PAIR    = 8'd2;

  // Credit balance ceiling
  localparam logic [7:0] CREDIT_MAX = 8'd255;

  // Saturating 8-bit add used when winnings are credited
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? CREDIT_MAX : sum[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/reel_stop_ctrl_payout_calc.sv
// ============================================================================
// Module      : reel_stop_ctrl_payout_calc
// Description : Combinational scoring of the three stopped reels against the
//               latched wager.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reel_stop_ctrl_payout_calc
  import reel_stop_ctrl_pkg::*;
#(
  parameter int JACKPOT_SYM = 7
) (
  input  logic [3:0] reel1,
  input  logic [3:0] reel2,
  input  logic [3:0] reel3,
  input  logic [1:0] bet,
  output logic [7:0] payout
);

  localparam logic [3:0] JACKPOT = 4'(JACKPOT_SYM);

  logic [7:0] w_bet8;
  logic       w_triple;
  logic       w_pair;

  assign w_bet8   = {6'd0, bet};
  assign w_triple = (reel1 == reel2) && (reel2 == reel3);
  // Only adjacent reels form a pair; reel1/reel3 alone does not pay
  assign w_pair   = (reel1 == reel2) || (reel2 == reel3);

  // Pick the multiplier by priority: jackpot, three-of-a-kind, adjacent pair
  always_comb begin
    payout = 8'd0;
    if (w_triple && (reel1 == JACKPOT)) begin
      payout = MULT_JACKPOT * w_bet8;
    end else if (w_triple) begin
      payout = MULT_TRIPLE * w_bet8;
    end else if (w_pair) begin
      payout = MULT_PAIR * w_bet8;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reel_stop_ctrl.sv
// ============================================================================
// Module      : reel_stop_ctrl
// Description : Samples three random symbol streams, animates and stops three
//               reels in sequence, scores the result and keeps the credit
//               balance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reel_stop_ctrl
  import reel_stop_ctrl_pkg::*;
#(
  parameter int SPIN_CYCLES   = 16,
  parameter int STOP_GAP      = 4,
  parameter int START_CREDITS = 20,
  parameter int JACKPOT_SYM   = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spin,
  input  logic [1:0] bet,
  input  logic [3:0] rnum1,
  input  logic [3:0] rnum2,
  input  logic [3:0] rnum3,
  output logic [3:0] reel1,
  output logic [3:0] reel2,
  output logic [3:0] reel3,
  output logic [7:0] credits,
  output logic [7:0] payout,
  output logic       win,
  output logic       busy,
  output logic       done,
  output logic       reject
);

  localparam int CNT_W = $clog2(SPIN_CYCLES + 2 * STOP_GAP + 1);

  // Counter value seen just before each reel's final load edge; the counter is
  // cleared on the accept edge and advances once per spinning edge.
  localparam logic [CNT_W-1:0] STOP1_AT = CNT_W'(SPIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] STOP2_AT = CNT_W'(SPIN_CYCLES + STOP_GAP - 1);
  localparam logic [CNT_W-1:0] STOP3_AT = CNT_W'(SPIN_CYCLES + 2 * STOP_GAP - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_bet;
  logic             w_accept;
  logic             w_refuse;
  logic             w_load1;
  logic             w_load2;
  logic             w_load3;
  logic [7:0]       w_payout;

  assign w_accept = (r_state == S_IDLE) && spin && (bet != 2'd0) && (credits >= {6'd0, bet});
  assign w_refuse = (r_state == S_IDLE) && spin && !w_accept;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Sequence through the spin, staggered stops, evaluation and result pulse
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)           w_next_state = S_SPIN;
      S_SPIN:  if (r_cnt == STOP1_AT)  w_next_state = S_STOP1;
      S_STOP1: if (r_cnt == STOP2_AT)  w_next_state = S_STOP2;
      S_STOP2: if (r_cnt == STOP3_AT)  w_next_state = S_EVAL;
      S_EVAL:                          w_next_state = S_DONE;
      S_DONE:                          w_next_state = S_IDLE;
      default:                         w_next_state = S_IDLE;
    endcase
  end

  // Decode status outputs and per-reel load enables from the current state
  always_comb begin
    busy    = (r_state != S_IDLE);
    done    = (r_state == S_DONE);
    w_load1 = (r_state == S_SPIN);
    w_load2 = (r_state == S_SPIN) || (r_state == S_STOP1);
    w_load3 = (r_state == S_SPIN) || (r_state == S_STOP1) || (r_state == S_STOP2);
  end

  // Edge counter: cleared on accept, advanced while any reel still loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_load3) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Wager is captured once at accept so later bet changes cannot affect scoring
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bet <= 2'd0;
    end else if (w_accept) begin
      r_bet <= bet;
    end
  end

  // Un-stopped reels follow their random source; stopped reels hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reel1 <= 4'd0;
      reel2 <= 4'd0;
      reel3 <= 4'd0;
    end else begin
      if (w_load1) reel1 <= rnum1;
      if (w_load2) reel2 <= rnum2;
      if (w_load3) reel3 <= rnum3;
    end
  end

  reel_stop_ctrl_payout_calc #(
    .JACKPOT_SYM (JACKPOT_SYM)
  ) u_payout_calc (
    .reel1  (reel1),
    .reel2  (reel2),
    .reel3  (reel3),
    .bet    (r_bet),
    .payout (w_payout)
  );

  // Debit on accept, credit winnings with saturation on the evaluation edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= 8'(START_CREDITS);
      payout  <= 8'd0;
      win     <= 1'b0;
    end else if (w_accept) begin
      credits <= credits - {6'd0, bet};
      payout  <= 8'd0;
      win     <= 1'b0;
    end else if (r_state == S_EVAL) begin
      credits <= sat_add(credits, w_payout);
      payout  <= w_payout;
      win     <= (w_payout != 8'd0);
    end
  end

  // Single-cycle refusal pulse for an unaffordable or zero wager
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reject <= 1'b0;
    end else begin
      reject <= w_refuse;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reel_stop_ctrl.sv
// ============================================================================
// Module      : tb_reel_stop_ctrl
// Description : Self-checking bench for reel_stop_ctrl: table vectors, random
//               spins against a behavioural model, and corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reel_stop_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spin = 1'b0;
  logic [1:0] bet = 2'd0;
  logic [3:0] rnum1 = 4'd0;
  logic [3:0] rnum2 = 4'd0;
  logic [3:0] rnum3 = 4'd0;
  logic [3:0] reel1;
  logic [3:0] reel2;
  logic [3:0] reel3;
  logic [7:0] credits;
  logic [7:0] payout;
  logic       win;
  logic       busy;
  logic       done;
  logic       reject;

  int checks = 0;
  int errors = 0;
  int model_credits;

  typedef struct {
    int r1;
    int r2;
    int r3;
    int bt;
    int pay;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  reel_stop_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .spin    (spin),
    .bet     (bet),
    .rnum1   (rnum1),
    .rnum2   (rnum2),
    .rnum3   (rnum3),
    .reel1   (reel1),
    .reel2   (reel2),
    .reel3   (reel3),
    .credits (credits),
    .payout  (payout),
    .win     (win),
    .busy    (busy),
    .done    (done),
    .reject  (reject)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoring rules straight from the game definition
  function automatic int score(input int a, input int b, input int c, input int bt);
    if (a == b && b == c) return (a == 7) ? 50 * bt : 10 * bt;
    if (a == b || b == c) return 2 * bt;
    return 0;
  endfunction

  function automatic logic [3:0] pick();
    if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
    return 4'($urandom_range(5, 7));
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_reel1"}, reel1, 0);
    check({tag, "_reel2"}, reel2, 0);
    check({tag, "_reel3"}, reel3, 0);
    check({tag, "_credits"}, credits, 20);
    check({tag, "_payout"}, payout, 0);
    check({tag, "_flags"}, {win, busy, done, reject}, 0);
  endtask

  // One spin request. rnd selects per-cycle random symbols; exp_pay < 0 means
  // the expected payout comes from the model using the symbols at stop edges.
  task automatic do_spin(input bit rnd, input int a, input int b, input int c,
                         input int bt, input int exp_pay);
    int h1[26];
    int h2[26];
    int h3[26];
    int exp_p;
    bet   = 2'(bt);
    rnum1 = 4'(a);
    rnum2 = 4'(b);
    rnum3 = 4'(c);
    spin  = 1'b1;
    if (bt == 0 || model_credits < bt) begin
      tick();
      check("reject_pulse", reject, 1);
      check("reject_credits", credits, model_credits);
      check("reject_busy", busy, 0);
      spin = 1'b0;
      tick();
      check("reject_clear", reject, 0);
      return;
    end
    tick();
    model_credits -= bt;
    check("accept_busy", busy, 1);
    check("accept_credits", credits, model_credits);
    check("accept_payout_win", {payout, win}, 0);
    check("accept_reject", reject, 0);
    for (int k = 1; k <= 25; k++) begin
      if (rnd) begin
        rnum1 = pick();
        rnum2 = pick();
        rnum3 = pick();
      end
      bet  = 2'($urandom_range(0, 3));
      spin = 1'($urandom_range(0, 1));
      h1[k] = int'(rnum1);
      h2[k] = int'(rnum2);
      h3[k] = int'(rnum3);
      tick();
      if (k < 25) begin
        check("spin_busy_nodone", {done, busy}, 1);
      end
    end
    exp_p = (exp_pay >= 0) ? exp_pay : score(h1[16], h2[20], h3[24], bt);
    model_credits = (model_credits + exp_p > 255) ? 255 : model_credits + exp_p;
    check("eval_done", {done, busy}, 3);
    check("eval_reel1", reel1, h1[16]);
    check("eval_reel2", reel2, h2[20]);
    check("eval_reel3", reel3, h3[24]);
    check("eval_payout", payout, exp_p);
    check("eval_win", win, (exp_p != 0) ? 1 : 0);
    check("eval_credits", credits, model_credits);
    spin = 1'b0;
    bet  = 2'(bt);
    tick();
    check("after_done_idle", {done, busy}, 0);
    check("after_done_payout_hold", payout, exp_p);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{7, 7, 7, 2, 100};
    tbl[1] = '{3, 3, 5, 1, 2};
    tbl[2] = '{1, 2, 3, 1, 0};
    tbl[3] = '{4, 4, 4, 3, 30};
    tbl[4] = '{2, 5, 5, 2, 4};
    tbl[5] = '{6, 1, 6, 3, 0};
    tbl[6] = '{7, 7, 3, 1, 2};

    model_credits = 20;
    rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rnum1 = pick();
      tick();
      check("idle_quiet", {busy, done, reject, reel1, credits}, {3'b000, 4'd0, 8'd20});
    end

    // Table vectors with symbols held constant through the spin
    for (int i = 0; i < 7; i++) begin
      do_spin(1'b0, tbl[i].r1, tbl[i].r2, tbl[i].r3, tbl[i].bt, tbl[i].pay);
    end

    // Random spins with symbols changing every cycle
    for (int i = 0; i < 30; i++) begin
      do_spin(1'b1, int'(pick()), int'(pick()), int'(pick()),
              int'($urandom_range(0, 3)), -1);
    end

    // Reset, then drain to 2 credits with losing bet-3 spins
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_credits = 20;
    check("reset2_credits", credits, 20);
    for (int i = 0; i < 6; i++) do_spin(1'b0, 1, 2, 3, 3, 0);
    check("drained_credits", credits, 2);
    do_spin(1'b0, 7, 7, 7, 3, 0);
    do_spin(1'b0, 7, 7, 7, 0, 0);

    // A held spin with a zero wager re-requests every cycle
    bet  = 2'd0;
    spin = 1'b1;
    tick();
    check("held_reject_1", reject, 1);
    tick();
    check("held_reject_2", reject, 1);
    spin = 1'b0;
    tick();
    check("held_reject_off", {reject, busy}, 0);

    // Climb to 250, then a jackpot saturates the balance
    do_spin(1'b0, 7, 7, 7, 2, 100);
    do_spin(1'b0, 7, 7, 7, 3, 150);
    do_spin(1'b0, 2, 2, 5, 3, 6);
    check("credits_250", credits, 250);
    do_spin(1'b0, 7, 7, 7, 1, 50);
    check("credits_saturated", credits, 255);

    // Reset mid-spin clears everything at once
    bet   = 2'd1;
    rnum1 = 4'd5;
    rnum2 = 4'd5;
    rnum3 = 4'd5;
    spin  = 1'b1;
    tick();
    spin = 1'b0;
    check("midspin_busy", busy, 1);
    for (int i = 0; i < 9; i++) tick();
    check("midspin_reel1_loaded", reel1, 5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midspin_reset");
    #3;
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", {busy, done, credits}, {2'b00, 8'd20});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
